divby3_tick_checker: RTL and testbench
======================================

Name: divby3_tick_checker

Overview:
- Downstream consumer of the divide-by-3 FSM output `y`, which is a one-cycle-high pulse every 3 clocks.
- Detects rising edges of `y`, re-issues them as a clean tick, and measures the spacing between ticks.
- Declares lock after a run of correct periods and flags a fault on any period error once locked.
- Used on the top-level `y_sv`/`y_v`/`y_vhd` outputs as a self-checking monitor and as a tick source for later stages.

Parameters:
- PERIOD, 3: expected clocks between rising edges of y_in; valid range 2..(2^CNT_W - 2).
- LOCK_COUNT, 4: consecutive correct periods required to enter LOCKED; valid range 1..15.
- CNT_W, 4: width of the period counter and of period_last.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, in, 1: single clock; every flop is on the rising edge.
- reset, in, 1: synchronous, active-high; clears all state.
- y_in, in, 1: divider output, synchronous to clk.
- clear, in, 1: one-cycle request to return to IDLE and zero err_count.
- tick_out, out, 1: registered rising-edge pulse of y_in.
- locked, out, 1: high in the LOCKED state.
- fault, out, 1: high in the FAULT state.
- err_count, out, ERR_W: saturating count of period errors.
- period_last, out, CNT_W: most recent measured period.

Behaviour:
- Reset: when reset is sampled high, all of the following are 0 on the next cycle: y_q, cnt, good_cnt, err_count, period_last, tick_out, locked, fault. State becomes IDLE. reset overrides clear and edges.
- Edge detect: edge = y_in & ~y_q, where y_q is y_in delayed one clock. tick_out is edge registered, giving one cycle of latency.
- Period counter cnt:
  - On edge, cnt <= 1.
  - Otherwise cnt <= cnt + 1, saturating at 2^CNT_W - 1.
  - The measured period is the value of cnt in the cycle edge is high.
  - On every edge outside IDLE, period_last <= measured period.
- State machine, with all outputs registered from state:
  - IDLE: wait for edge, then go to MEASURE with good_cnt = 0. No period check is made on this first edge.
  - MEASURE, on edge with measured == PERIOD: good_cnt++. If good_cnt reaches LOCK_COUNT, go to LOCKED.
  - MEASURE, on edge with measured != PERIOD: good_cnt <= 0, err_count++, stay in MEASURE.
  - MEASURE, no edge: no check, even if cnt saturates.
  - LOCKED, edge with measured == PERIOD: stay in LOCKED.
  - LOCKED, early edge (measured < PERIOD): err_count++, go to FAULT.
  - LOCKED, missed edge (cnt == PERIOD and no edge this cycle): err_count++, go to FAULT.
  - FAULT: sticky; edges still update period_last and tick_out; no further err_count increments.
  - clear in any state: go to IDLE, err_count <= 0, good_cnt <= 0. clear wins over a simultaneous edge or error; that edge is not counted but tick_out still fires.
- err_count saturates at 2^ERR_W - 1 and never wraps.
- locked and fault are never both high.

Optional Feature:
- Macro TICK_CHECK_AUTORELOCK_EN.
- Defined:
  - In FAULT, edges are checked as in MEASURE using good_cnt.
  - LOCK_COUNT consecutive correct periods return the block to LOCKED.
  - Each mismatch in FAULT increments err_count and zeroes good_cnt.
- Undefined: FAULT is sticky until clear or reset, as described in Behaviour.

Test Plan:
- Lock-in:
  - Stimulus: PERIOD=3, LOCK_COUNT=4. Hold reset for 2 cycles, then drive y_in as the repeating pattern 1,0,0.
  - Response: tick_out is high 1 cycle after each y_in rise. locked rises the cycle after the 5th edge. period_last = 3, err_count = 0.
- Dropped pulse:
  - Stimulus: while locked, suppress one y_in pulse.
  - Response: fault = 1 and locked = 0 the cycle after cnt == 3 with no edge; err_count = 1.
- Wrong period:
  - Stimulus: feed a period-4 pattern 1,0,0,0 for 6 edges from IDLE.
  - Response: locked stays 0, err_count = 5, period_last = 4.
- Clear and relock:
  - Stimulus: assert clear for 1 cycle in FAULT, then resume the period-3 pattern.
  - Response: fault = 0 and err_count = 0 next cycle; locked returns after 5 edges.
- Saturation:
  - Stimulus: ERR_W=2, 5 mismatched periods in MEASURE.
  - Response: err_count = 3, holding.
- Reset mid-LOCKED:
  - Stimulus: pulse reset for 1 cycle while locked.
  - Response: all outputs are 0 next cycle; relock needs 5 new edges.
- AUTORELOCK build:
  - Stimulus: after the dropped-pulse fault, feed 4 correct periods.
  - Response: locked = 1 again and err_count stays 1.

Source files
------------

// File: rtl/divby3_tick_checker.sv
`timescale 1ns/1ps
// divby3_tick_checker
// Monitors the one-in-PERIOD pulse train from the divide-by-3 FSM. It re-issues
// each rising edge of y_in as a registered tick and measures the spacing between
// edges. After LOCK_COUNT correct periods it reports locked. Once locked, any
// period error is reported as a fault, and err_count saturates.
//
// Optional build macro: TICK_CHECK_AUTORELOCK_EN
//   undefined: FAULT is sticky until clear or reset.
//   defined  : in FAULT, edges are checked again and LOCK_COUNT correct periods
//              return the block to LOCKED. The first edge after the fault is only
//              used to realign to the pulse train.
module divby3_tick_checker #(
    parameter int unsigned PERIOD     = 3,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             y_in,
    input  logic             clear,
    output logic             tick_out,
    output logic             locked,
    output logic             fault,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] period_last
);

    localparam int unsigned       GOOD_W   = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [ERR_W-1:0]  ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [CNT_W-1:0]  PERIOD_C = CNT_W'(PERIOD);
    localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic                y_q,           y_d;
    logic                tick_out_q,    tick_out_d;
    logic                locked_q,      locked_d;
    logic                fault_q,       fault_d;
    logic [CNT_W-1:0]    cnt_q,         cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q,    good_cnt_d;
    logic [ERR_W-1:0]    err_count_q,   err_count_d;
    logic [CNT_W-1:0]    period_last_q, period_last_d;
`ifdef TICK_CHECK_AUTORELOCK_EN
    logic                resync_q,      resync_d;
`endif

    logic                edge_c;
    logic                period_ok_c;
    logic [GOOD_W-1:0]   good_inc_c;
    logic                err_inc;

    // Rising edge of y_in and the period test; cnt_q is the measured period on an edge
    assign edge_c      = y_in & ~y_q;
    assign period_ok_c = (cnt_q == PERIOD_C);
    assign good_inc_c  = good_cnt_q + GOOD_W'(1);

    // Next-state logic for the period counter, lock state machine and error counter
    always_comb begin
        y_d           = y_in;
        tick_out_d    = edge_c;
        cnt_d         = cnt_q;
        state_d       = state_q;
        good_cnt_d    = good_cnt_q;
        err_count_d   = err_count_q;
        period_last_d = period_last_q;
        err_inc       = 1'b0;
`ifdef TICK_CHECK_AUTORELOCK_EN
        resync_d      = resync_q;
`endif

        if (edge_c) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // The first edge only starts the measurement; it has no reference
                if (edge_c) begin
                    state_d    = ST_MEASURE;
                    good_cnt_d = '0;
                end
            end
            ST_MEASURE: begin
                if (edge_c) begin
                    period_last_d = cnt_q;
                    if (period_ok_c) begin
                        good_cnt_d = good_inc_c;
                        if (good_inc_c == LOCK_C) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                        err_inc    = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (edge_c) begin
                    period_last_d = cnt_q;
                end
                // Early edge, or the expected edge did not arrive on time
                if ((edge_c && !period_ok_c) || (!edge_c && period_ok_c)) begin
                    err_inc    = 1'b1;
                    state_d    = ST_FAULT;
                    good_cnt_d = '0;
`ifdef TICK_CHECK_AUTORELOCK_EN
                    resync_d   = 1'b1;
`endif
                end
            end
            ST_FAULT: begin
                if (edge_c) begin
                    period_last_d = cnt_q;
`ifdef TICK_CHECK_AUTORELOCK_EN
                    if (resync_q) begin
                        resync_d = 1'b0;
                    end else if (period_ok_c) begin
                        good_cnt_d = good_inc_c;
                        if (good_inc_c == LOCK_C) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                        err_inc    = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (err_inc && (err_count_q != ERR_MAX)) begin
            err_count_d = err_count_q + ERR_W'(1);
        end

        // clear wins over any edge or error seen in the same cycle
        if (clear) begin
            state_d       = ST_IDLE;
            good_cnt_d    = '0;
            err_count_d   = '0;
            period_last_d = period_last_q;
`ifdef TICK_CHECK_AUTORELOCK_EN
            resync_d      = 1'b0;
`endif
        end

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            y_q           <= 1'b0;
            tick_out_q    <= 1'b0;
            locked_q      <= 1'b0;
            fault_q       <= 1'b0;
            cnt_q         <= '0;
            good_cnt_q    <= '0;
            err_count_q   <= '0;
            period_last_q <= '0;
`ifdef TICK_CHECK_AUTORELOCK_EN
            resync_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            y_q           <= y_d;
            tick_out_q    <= tick_out_d;
            locked_q      <= locked_d;
            fault_q       <= fault_d;
            cnt_q         <= cnt_d;
            good_cnt_q    <= good_cnt_d;
            err_count_q   <= err_count_d;
            period_last_q <= period_last_d;
`ifdef TICK_CHECK_AUTORELOCK_EN
            resync_q      <= resync_d;
`endif
        end
    end

    assign tick_out    = tick_out_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign err_count   = err_count_q;
    assign period_last = period_last_q;

    // locked and fault are decoded from one state and can never overlap
    a_lock_fault_excl: assert property (@(posedge clk) !(locked_q && fault_q));

endmodule

// File: tb/tb_divby3_tick_checker.sv
`timescale 1ns/1ps
// Self-checking bench for divby3_tick_checker: directed scenarios plus a random
// pulse train checked against a behavioural model built on edge timestamps.
module tb_divby3_tick_checker;

    localparam int unsigned PERIOD     = 3;
    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned ERR_W      = 8;
    localparam int          CNT_SAT    = (1 << CNT_W) - 1;

    localparam int MD_IDLE    = 0;
    localparam int MD_MEASURE = 1;
    localparam int MD_LOCKED  = 2;
    localparam int MD_FAULT   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             y_in;
    logic             clear;
    logic             tick_out, locked, fault;
    logic [ERR_W-1:0] err_count;
    logic [CNT_W-1:0] period_last;
    logic             tick2, locked2, fault2;
    logic [1:0]       err2;
    logic [CNT_W-1:0] plast2;

    int total = 0;
    int bad   = 0;

    // Reference model state: cycle index, timestamp of last edge, run of good periods
    int m_k      = 0;
    int m_anchor = 0;
    int m_mode   = MD_IDLE;
    int m_run    = 0;
    int m_errs   = 0;
    int m_plast  = 0;
    bit m_prev_y = 1'b0;
    bit m_tick   = 1'b0;
    bit m_resync = 1'b0;

    always #5 clk = ~clk;

    divby3_tick_checker #(
        .PERIOD(PERIOD), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .y_in(y_in), .clear(clear),
        .tick_out(tick_out), .locked(locked), .fault(fault),
        .err_count(err_count), .period_last(period_last)
    );

    divby3_tick_checker #(
        .PERIOD(PERIOD), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W), .ERR_W(2)
    ) dut_sat (
        .clk(clk), .reset(reset), .y_in(y_in), .clear(clear),
        .tick_out(tick2), .locked(locked2), .fault(fault2),
        .err_count(err2), .period_last(plast2)
    );

    // Period = cycles between edge timestamps (saturated); errors kept unbounded
    always @(posedge clk) begin : ref_model
        int gap;
        bit e;
        m_k++;
        if (reset) begin
            m_anchor = m_k + 1;
            m_prev_y = 1'b0;
            m_tick   = 1'b0;
            m_mode   = MD_IDLE;
            m_run    = 0;
            m_errs   = 0;
            m_plast  = 0;
            m_resync = 1'b0;
        end else begin
            e        = y_in && !m_prev_y;
            m_prev_y = y_in;
            m_tick   = e;
            gap      = m_k - m_anchor;
            if (gap > CNT_SAT) gap = CNT_SAT;
            if (clear) begin
                m_mode = MD_IDLE;
                m_run  = 0;
                m_errs = 0;
                m_resync = 1'b0;
            end else if (m_mode == MD_IDLE) begin
                if (e) begin
                    m_mode = MD_MEASURE;
                    m_run  = 0;
                end
            end else begin
                if (e) m_plast = gap;
                if (m_mode == MD_MEASURE) begin
                    if (e) begin
                        if (gap == PERIOD) begin
                            m_run++;
                            if (m_run == LOCK_COUNT) m_mode = MD_LOCKED;
                        end else begin
                            m_run = 0;
                            m_errs++;
                        end
                    end
                end else if (m_mode == MD_LOCKED) begin
                    if ((e && gap != PERIOD) || (!e && gap == PERIOD)) begin
                        m_errs++;
                        m_mode   = MD_FAULT;
                        m_run    = 0;
                        m_resync = 1'b1;
                    end
                end else begin
`ifdef TICK_CHECK_AUTORELOCK_EN
                    if (e) begin
                        if (m_resync) begin
                            m_resync = 1'b0;
                        end else if (gap == PERIOD) begin
                            m_run++;
                            if (m_run == LOCK_COUNT) m_mode = MD_LOCKED;
                        end else begin
                            m_run = 0;
                            m_errs++;
                        end
                    end
`endif
                end
            end
            if (e) m_anchor = m_k;
        end
    end

    // Drive one cycle of inputs and land just after the sampling edge
    task automatic step(input logic yv, input logic clr, input logic rst);
        y_in  = yv;
        clear = clr;
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        total++;
        if ({tick_out, locked, fault, err_count, period_last} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0",
                     tick_out, locked, fault, err_count, period_last);
        end
        total++;
        if ({tick2, locked2, fault2, err2, plast2} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_sat got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0",
                     tick2, locked2, fault2, err2, plast2);
        end
    endtask

    task automatic test_lock_in();
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (tick_out !== 1'b1) begin
                bad++;
                $display("FAIL lockin_tick edge=%0d got=%b exp=1", p, tick_out);
            end
            total++;
            if (locked !== (p == 4)) begin
                bad++;
                $display("FAIL lockin_locked edge=%0d got=%b exp=%b", p, locked, (p == 4));
            end
            step(1'b0, 1'b0, 1'b0);
            total++;
            if (tick_out !== 1'b0) begin
                bad++;
                $display("FAIL lockin_tick_low edge=%0d got=%b exp=0", p, tick_out);
            end
            step(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (period_last !== 4'd3 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL lockin_period got=%0d/%0d exp=3/0", period_last, err_count);
        end
    endtask

    task automatic test_dropped_pulse();
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL drop_prelocked got=%b exp=1", locked);
        end
        step(1'b0, 1'b0, 1'b0);
        total++;
        if (fault !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL drop_fault got=f%b l%b e%0d exp=f1 l0 e1", fault, locked, err_count);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            if (p == 0) begin
                total++;
                if (period_last !== 4'd6) begin
                    bad++;
                    $display("FAIL drop_plast got=%0d exp=6", period_last);
                end
            end
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
`ifdef TICK_CHECK_AUTORELOCK_EN
        total++;
        if (locked !== 1'b1 || fault !== 1'b0 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL drop_relock got=l%b f%b e%0d exp=l1 f0 e1", locked, fault, err_count);
        end
`else
        total++;
        if (locked !== 1'b0 || fault !== 1'b1 || err_count !== 8'd1) begin
            bad++;
            $display("FAIL drop_sticky got=l%b f%b e%0d exp=l0 f1 e1", locked, fault, err_count);
        end
`endif
    endtask

    task automatic test_clear_relock();
        if (m_mode != MD_FAULT) step(1'b0, 1'b0, 1'b0);
        total++;
        if (fault !== 1'b1) begin
            bad++;
            $display("FAIL clear_prefault got=%b exp=1", fault);
        end
        step(1'b0, 1'b1, 1'b0);
        total++;
        if (fault !== 1'b0 || locked !== 1'b0 || err_count !== 8'd0) begin
            bad++;
            $display("FAIL clear_outputs got=f%b l%b e%0d exp=f0 l0 e0", fault, locked, err_count);
        end
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (locked !== (p == 4)) begin
                bad++;
                $display("FAIL clear_relock edge=%0d got=%b exp=%b", p, locked, (p == 4));
            end
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_early_edge();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        total++;
        if (fault !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || period_last !== 4'd2) begin
            bad++;
            $display("FAIL early_edge got=f%b l%b e%0d p%0d exp=f1 l0 e1 p2",
                     fault, locked, err_count, period_last);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrong_period();
        step(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 8; p++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (locked !== 1'b0) begin
                bad++;
                $display("FAIL wrong_locked edge=%0d got=%b exp=0", p, locked);
            end
            if (p == 5) begin
                total++;
                if (err_count !== 8'd5 || period_last !== 4'd4 || err2 !== 2'd3) begin
                    bad++;
                    $display("FAIL wrong_err got=e%0d p%0d s%0d exp=e5 p4 s3",
                             err_count, period_last, err2);
                end
            end
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (err_count !== 8'd7 || err2 !== 2'd3) begin
            bad++;
            $display("FAIL wrong_sat_hold got=e%0d s%0d exp=e7 s3", err_count, err2);
        end
    endtask

    task automatic test_reset_mid_locked();
        step(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL rst_prelocked got=%b exp=1", locked);
        end
        step(1'b0, 1'b0, 1'b1);
        total++;
        if ({tick_out, locked, fault, err_count, period_last} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b/%b/%b/%0d/%0d exp=0/0/0/0/0",
                     tick_out, locked, fault, err_count, period_last);
        end
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if (locked !== (p == 4)) begin
                bad++;
                $display("FAIL rst_relock edge=%0d got=%b exp=%b", p, locked, (p == 4));
            end
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        int           gap;
        int           r;
        logic         clr;
        logic         rst;
        logic [23:0]  exp_v;
        logic [23:0]  act_v;
        logic [7:0]   e8;
        logic [1:0]   e2;
        step(1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      gap = 3;
            else if (r < 80) gap = 2;
            else if (r < 90) gap = 4;
            else             gap = int'($urandom_range(5, 20));
            for (int c = 0; c < gap; c++) begin
                clr = ($urandom_range(0, 199) == 0);
                rst = ($urandom_range(0, 399) == 0);
                step(c == 0, clr, rst);
                e8 = (m_errs > 255) ? 8'd255 : 8'(m_errs);
                e2 = (m_errs > 3) ? 2'd3 : 2'(m_errs);
                exp_v = {m_tick, (m_mode == MD_LOCKED), (m_mode == MD_FAULT), e8, 4'(m_plast),
                         m_tick, (m_mode == MD_LOCKED), (m_mode == MD_FAULT), e2, 4'(m_plast)};
                act_v = {tick_out, locked, fault, err_count, period_last,
                         tick2, locked2, fault2, err2, plast2};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL random_cycle k=%0d got=%h exp=%h", m_k, act_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        y_in  = 1'b0;
        clear = 1'b0;
        test_reset();
        test_lock_in();
        test_dropped_pulse();
        test_clear_relock();
        test_early_edge();
        test_wrong_period();
        test_reset_mid_locked();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
